hand_accumulator: RTL
=====================

Name: hand_accumulator

Overview:
- Sequential, parametrised successor to the combinational three-card baccarat scorer.
- Accepts cards one per handshake, holds a running mod-10 hand score, and records the raw card codes in slot registers for the HEX display path.
- Flags a natural (8 or 9 on the first two cards) and rejects cards beyond hand capacity.
- Sits between the card dealer and the datapath/display; one instance per hand (player, dealer).

Parameters:
- MAX_CARDS, 3, hand capacity in cards; legal range 2..8.
- CARD_W, 4, width of a card code. 1..9 are face value; 0 and 10..(2^CARD_W-1) score 0.
- CNT_W, $clog2(MAX_CARDS+1), width of the card counter. Derived; do not override.

Ports:
- slow_clock  input  1  Sole clock. All state changes on rising edge.
- resetb  input  1  Asynchronous, active-low reset.
- clear  input  1  Synchronous hand clear, active-high.
- card_valid  input  1  card_in holds a card offered this cycle.
- card_in  input  CARD_W  Raw card code.
- card_ready  output  1  Hand can accept a card. Equals !full; combinational from registers only.
- score  output  4  Registered running score, 0..9.
- count  output  CNT_W  Number of cards accepted, 0..MAX_CARDS.
- full  output  1  count == MAX_CARDS.
- natural  output  1  Sticky: set when the second accepted card leaves score at 8 or 9.
- card_err  output  1  One-cycle pulse: a card was offered while full and was dropped.
- hand  output  MAX_CARDS*CARD_W  Raw codes of accepted cards. Slot i is at [i*CARD_W +: CARD_W]; slot 0 is the first card. Unfilled slots read 0.

Behaviour:
- Reset: resetb low at any time, mid-hand included, immediately forces the following, independent of the clock:
  - score=0, count=0, natural=0, card_err=0, every hand slot=0.
  - full=0 and card_ready=1.
- Card value: val = card_in when 1 <= card_in <= 9, else 0. Computed at CARD_W+1 bits; no truncation into 4 bits before the modulo.
- Accept condition: card_valid && card_ready && !clear, sampled at a rising edge. On accept:
  - score <= (score + val >= 10) ? score + val - 10 : score + val. Max intermediate is 18, so one conditional subtract suffices.
  - hand slot[count] <= card_in, storing the raw code (e.g. 12, not 0).
  - count <= count + 1.
  - If this is the second card (count was 1) and the new score >= 8, natural <= 1.
- Latency: score, count and hand reflect an accepted card one clock after the accepting edge. card_ready/full update on the same edge that makes count reach MAX_CARDS.
- Back-to-back: a card may be accepted every cycle while not full.
- Full: card_valid && full && !clear leaves all state unchanged; card_err=1 for exactly the next cycle. Otherwise card_err=0 each cycle.
- Clear: clear=1 at an edge sets score=0, count=0, natural=0, all slots=0 and card_err=0. clear has priority over a simultaneous card_valid; that card is dropped with no card_err.
- natural is sticky until clear or reset. It is never set by a third or later card, and never set when only one card has been accepted.
- No FSM beyond the count-driven states EMPTY (count 0), PARTIAL (1..MAX_CARDS-1) and FULL (MAX_CARDS). Transitions only on accept (+1), clear (to EMPTY) or reset (to EMPTY).

Test Plan:
- Reset, then cards 5,5,1 back-to-back (card_valid held 3 cycles) -> score 0,5,0,1 on successive cycles; count=3; full=1; card_ready=0; natural=0; hand slots {5,5,1}.
- Cards 4 then 4 -> score=8 and natural=1 after the second card. Then 9 -> score=7, natural stays 1. Then clear -> score=0, count=0, natural=0, hand=0.
- Cards 10,3,13 -> score 0,3,3; hand slots hold raw codes {10,3,13}. Cards 9,10,11 -> score=9, natural=1. Cards 2,8,10 -> score=0.
- With the hand full from 8,7,6 (score=1), offer card 9 -> score stays 1, count stays 3, card_err high exactly one cycle. Same stimulus with clear=1 -> hand cleared, card_err=0.
- Assert resetb low asynchronously (off clock edge) after two cards 6,2 -> outputs zero before the next edge; card_ready=1.
- Rebuild with MAX_CARDS=5, feed 9,9,9,9,9 -> score 9,8,7,6,5; full only after the fifth card; a sixth card produces card_err.

Source files
------------

// File: rtl/hand_accumulator.sv
// rtl/hand_accumulator.sv - sequential baccarat hand scorer with raw card slots
// Accepts one card per handshake, keeps a mod-10 score, flags naturals and overflow.
module hand_accumulator #(
  parameter int MAX_CARDS = 3,
  parameter int CARD_W    = 4,
  parameter int CNT_W     = $clog2(MAX_CARDS + 1)
) (
  input  logic                         slow_clock,
  input  logic                         resetb,
  input  logic                         clear,
  input  logic                         card_valid,
  input  logic [CARD_W-1:0]            card_in,
  output logic                         card_ready,
  output logic [3:0]                   score,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         natural,
  output logic                         card_err,
  output logic [MAX_CARDS*CARD_W-1:0]  hand
);

  // Sum width must hold both a raw code and the 0..18 intermediate score.
  localparam int SW = (CARD_W + 1 > 5) ? CARD_W + 1 : 5;
  localparam int HW = MAX_CARDS * CARD_W;

  logic [3:0]       score_q, score_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             natural_q, natural_d;
  logic             card_err_q, card_err_d;
  logic [HW-1:0]    hand_q, hand_d;

  logic             full_w;
  logic             accept;
  logic [SW-1:0]    card_ext;
  logic [SW-1:0]    val;
  logic [SW-1:0]    sum;

  assign full_w = (count_q == CNT_W'(MAX_CARDS));
  assign accept = card_valid && !full_w && !clear;

  always_comb begin
    card_ext = SW'(card_in);
    val      = ((card_ext >= SW'(1)) && (card_ext <= SW'(9))) ? card_ext : '0;
    sum      = SW'(score_q) + val;
  end

  always_comb begin
    score_d    = score_q;
    count_d    = count_q;
    natural_d  = natural_q;
    hand_d     = hand_q;
    card_err_d = 1'b0;
    if (clear) begin
      score_d   = 4'd0;
      count_d   = '0;
      natural_d = 1'b0;
      hand_d    = '0;
    end else if (accept) begin
      score_d = (sum >= SW'(10)) ? 4'(sum - SW'(10)) : 4'(sum);
      count_d = count_q + CNT_W'(1);
      for (int i = 0; i < MAX_CARDS; i++) begin
        if (count_q == CNT_W'(i)) begin
          hand_d[i*CARD_W +: CARD_W] = card_in;
        end
      end
      // Only the second card can make a natural; the flag is sticky afterwards.
      if ((count_q == CNT_W'(1)) && (score_d >= 4'd8)) begin
        natural_d = 1'b1;
      end
    end else if (card_valid) begin
      card_err_d = 1'b1;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      score_q    <= 4'd0;
      count_q    <= '0;
      natural_q  <= 1'b0;
      card_err_q <= 1'b0;
      hand_q     <= '0;
    end else begin
      score_q    <= score_d;
      count_q    <= count_d;
      natural_q  <= natural_d;
      card_err_q <= card_err_d;
      hand_q     <= hand_d;
    end
  end

  assign score      = score_q;
  assign count      = count_q;
  assign full       = full_w;
  assign card_ready = !full_w;
  assign natural    = natural_q;
  assign card_err   = card_err_q;
  assign hand       = hand_q;

endmodule
